// File: rtl/seg_595_multi_scan_pkg.sv
// Shared constants for the multiplexed 7-segment / 74HC595 scan driver:
// active-high glyph codes, scan FSM encoding and bit positions.
package seg_595_multi_scan_pkg;

  localparam logic [7:0] SEG_0     = 8'h3F;
  localparam logic [7:0] SEG_1     = 8'h06;
  localparam logic [7:0] SEG_2     = 8'h5B;
  localparam logic [7:0] SEG_3     = 8'h4F;
  localparam logic [7:0] SEG_4     = 8'h66;
  localparam logic [7:0] SEG_5     = 8'h6D;
  localparam logic [7:0] SEG_6     = 8'h7D;
  localparam logic [7:0] SEG_7     = 8'h07;
  localparam logic [7:0] SEG_8     = 8'h7F;
  localparam logic [7:0] SEG_9     = 8'h6F;
  localparam logic [7:0] SEG_A     = 8'h77;
  localparam logic [7:0] SEG_B     = 8'h7C;
  localparam logic [7:0] SEG_C     = 8'h39;
  localparam logic [7:0] SEG_D     = 8'h5E;
  localparam logic [7:0] SEG_E     = 8'h79;
  localparam logic [7:0] SEG_F     = 8'h71;
  localparam logic [7:0] SEG_MINUS = 8'h40;
  localparam logic [7:0] SEG_BLANK = 8'h00;

  // Segment byte is {dp,g,f,e,d,c,b,a}; the select bits sit above it in the chain word.
  localparam int SEG_W  = 8;
  localparam int DP_BIT = 7;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LATCH = 2'd2,
    ST_HOLD  = 2'd3
  } scan_state_t;

  function automatic logic [7:0] seg_glyph(input logic [3:0] nib);
    logic [7:0] g;
    case (nib)
      4'h0: g = SEG_0;
      4'h1: g = SEG_1;
      4'h2: g = SEG_2;
      4'h3: g = SEG_3;
      4'h4: g = SEG_4;
      4'h5: g = SEG_5;
      4'h6: g = SEG_6;
      4'h7: g = SEG_7;
      4'h8: g = SEG_8;
      4'h9: g = SEG_9;
      4'hA: g = SEG_A;
      4'hB: g = SEG_B;
      4'hC: g = SEG_C;
      4'hD: g = SEG_D;
      4'hE: g = SEG_E;
      default: g = SEG_F;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/seg_595_multi_scan_seg7_encode.sv
// Combinational glyph encoder: one nibble plus blank/minus/dp flags to an
// active-high segment byte. Blank wins over minus, minus wins over the digit.
module seg7_encode
  import seg_595_multi_scan_pkg::*;
(
  input  logic [3:0] nib,
  input  logic       hex_mode,
  input  logic       blank,
  input  logic       minus,
  input  logic       dp,
  output logic [7:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      if (minus) begin
        seg = SEG_MINUS;
      end else if (hex_mode || (nib <= 4'd9)) begin
        seg = seg_glyph(nib);
      end
      // Decimal-mode nibbles above 9 leave the glyph dark but keep their point.
      if (dp) seg[DP_BIT] = 1'b1;
    end
  end

endmodule

// File: rtl/seg_595_multi_scan.sv
// Time-multiplexed DIGITS-digit 7-segment driver feeding a 74HC595 chain, with
// frame snapshot, leading-zero blanking, sign placement and oe PWM brightness.
module seg_595_multi_scan
  import seg_595_multi_scan_pkg::*;
#(
  parameter int DIGITS         = 6,
  parameter int SHCP_HALF      = 1,
  parameter int SCAN_DIV       = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit SEL_ACTIVE_LOW = 1'b1
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     point,
  input  logic                  seg_en,
  input  logic                  sign,
  input  logic                  hex_mode,
  input  logic                  lzb_en,
  input  logic [3:0]            bright,
  output logic                  stcp,
  output logic                  shcp,
  output logic                  ds,
  output logic                  oe,
  output logic                  frame_done
);

  localparam int W        = SEG_W + DIGITS;
  localparam int DIG_W    = $clog2(DIGITS);
  localparam int SLOT_W   = $clog2(SCAN_DIV);
  localparam int HALF_W   = $clog2(SHCP_HALF + 1);
  localparam int BIT_W    = $clog2(W);
  localparam int PWM_STEP = SCAN_DIV / 16;

  localparam logic [DIG_W-1:0]  LAST_DIG  = DIG_W'(DIGITS - 1);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(SCAN_DIV - 1);
  localparam logic [HALF_W-1:0] LAST_HALF = HALF_W'(SHCP_HALF - 1);

  logic [SLOT_W-1:0] slot_cnt, slot_nxt;
  logic [DIG_W-1:0]  dig_idx;
  logic              slot_wrap, frame_start;

  logic [4*DIGITS-1:0] snap_data, src_data;
  logic [DIGITS-1:0]   snap_point, src_point;
  logic                snap_seg_en, snap_sign, snap_hex, snap_lzb;
  logic                src_seg_en, src_sign, src_hex, src_lzb;
  logic [3:0]          snap_bright, src_bright;

  logic [DIG_W-1:0]  hi_idx;
  logic [3:0]        cur_nib;
  logic              cur_dp, lz_blank, minus_here, enc_blank;
  logic [7:0]        seg_hi, seg_out;
  logic [DIGITS-1:0] sel_hi, sel_out;
  logic [W-1:0]      word;
  logic              oe_on_nxt;

  scan_state_t       state;
  logic [W-2:0]      shreg;
  logic [BIT_W-1:0]  bit_cnt;
  logic [HALF_W-1:0] half_cnt;

  assign slot_wrap   = (slot_cnt == LAST_SLOT);
  assign slot_nxt    = slot_wrap ? '0 : slot_cnt + 1'b1;
  assign frame_start = (slot_cnt == '0) && (dig_idx == '0);

  // The first slot of a frame reads the live inputs (the same values being captured),
  // every later slot reads the snapshot, so a frame never mixes two input sets.
  assign src_data   = frame_start ? data     : snap_data;
  assign src_point  = frame_start ? point    : snap_point;
  assign src_seg_en = frame_start ? seg_en   : snap_seg_en;
  assign src_sign   = frame_start ? sign     : snap_sign;
  assign src_hex    = frame_start ? hex_mode : snap_hex;
  assign src_lzb    = frame_start ? lzb_en   : snap_lzb;
  assign src_bright = frame_start ? bright   : snap_bright;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      slot_cnt <= '0;
      dig_idx  <= '0;
    end else begin
      slot_cnt <= slot_nxt;
      if (slot_wrap) dig_idx <= (dig_idx == LAST_DIG) ? '0 : dig_idx + 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      snap_data   <= '0;
      snap_point  <= '0;
      snap_seg_en <= 1'b0;
      snap_sign   <= 1'b0;
      snap_hex    <= 1'b0;
      snap_lzb    <= 1'b0;
      snap_bright <= '0;
    end else if (frame_start) begin
      snap_data   <= data;
      snap_point  <= point;
      snap_seg_en <= seg_en;
      snap_sign   <= sign;
      snap_hex    <= hex_mode;
      snap_lzb    <= lzb_en;
      snap_bright <= bright;
    end
  end

  // Current-digit resolve: highest nonzero position drives blanking and sign slot.
  always_comb begin
    hi_idx  = '0;
    cur_nib = '0;
    cur_dp  = 1'b0;
    sel_hi  = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (src_data[4*k +: 4] != 4'h0) hi_idx = DIG_W'(k);
      if (DIG_W'(k) == dig_idx) begin
        cur_nib   = src_data[4*k +: 4];
        cur_dp    = src_point[k];
        sel_hi[k] = 1'b1;
      end
    end
    lz_blank = src_lzb && (dig_idx > hi_idx);
    if (src_lzb) begin
      minus_here = src_sign && lz_blank && ({1'b0, dig_idx} == ({1'b0, hi_idx} + 1'b1));
    end else begin
      minus_here = src_sign && (dig_idx == LAST_DIG);
    end
    enc_blank = !src_seg_en || (lz_blank && !minus_here);
  end

  seg7_encode u_encode (
    .nib      (cur_nib),
    .hex_mode (src_hex),
    .blank    (enc_blank),
    .minus    (minus_here),
    .dp       (cur_dp && !lz_blank),
    .seg      (seg_hi)
  );

  assign seg_out   = SEG_ACTIVE_LOW ? ~seg_hi : seg_hi;
  assign sel_out   = SEL_ACTIVE_LOW ? ~sel_hi : sel_hi;
  assign word      = {sel_out, seg_out};
  assign oe_on_nxt = int'(slot_nxt) < ((int'(src_bright) + 1) * PWM_STEP);

  // LOAD counts as the first shcp-low cycle, so the last bit's high phase ends at
  // cycle 2*SHCP_HALF*W-1 and stcp rises exactly at 2*SHCP_HALF*W.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state      <= ST_LOAD;
      stcp       <= 1'b0;
      shcp       <= 1'b0;
      ds         <= 1'b0;
      oe         <= 1'b1;
      frame_done <= 1'b0;
      bit_cnt    <= '0;
      half_cnt   <= '0;
    end else begin
      oe         <= !oe_on_nxt;
      frame_done <= 1'b0;
      case (state)
        ST_LOAD: begin
          ds      <= word[W-1];
          bit_cnt <= BIT_W'(W - 1);
          stcp    <= 1'b0;
          if (SHCP_HALF == 1) begin
            shcp     <= 1'b1;
            half_cnt <= '0;
          end else begin
            shcp     <= 1'b0;
            half_cnt <= HALF_W'(1);
          end
          state <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (half_cnt == LAST_HALF) begin
            half_cnt <= '0;
            if (!shcp) begin
              shcp <= 1'b1;
            end else if (bit_cnt == '0) begin
              shcp       <= 1'b0;
              stcp       <= 1'b1;
              frame_done <= (dig_idx == LAST_DIG);
              state      <= ST_LATCH;
            end else begin
              shcp    <= 1'b0;
              bit_cnt <= bit_cnt - 1'b1;
              ds      <= shreg[bit_cnt - 1'b1];
            end
          end else begin
            half_cnt <= half_cnt + 1'b1;
          end
        end
        ST_LATCH: begin
          if (half_cnt == LAST_HALF) begin
            stcp     <= 1'b0;
            half_cnt <= '0;
            state    <= ST_HOLD;
          end else begin
            half_cnt <= half_cnt + 1'b1;
          end
        end
        default: begin
          if (slot_wrap) state <= ST_LOAD;
        end
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (state == ST_LOAD) shreg <= word[W-2:0];
  end

endmodule

// File: tb/tb_seg_595_multi_scan.sv
// Directed bench for seg_595_multi_scan (DIGITS=6, SHCP_HALF=1, SCAN_DIV=64):
// decodes the serial 595 stream back into latched words and checks them.
module tb_seg_595_multi_scan;

  localparam int DIGITS = 6;
  localparam int W      = 14;
  localparam int SLOT   = 64;
  localparam int T_LAT  = 28;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] data = '0;
  logic [5:0]  point = '0;
  logic        seg_en = 1'b0, sign = 1'b0, hex_mode = 1'b0, lzb_en = 1'b0;
  logic [3:0]  bright = '0;
  logic        stcp, shcp, ds, oe, frame_done;

  always #5 clk = ~clk;

  seg_595_multi_scan #(
    .DIGITS(DIGITS), .SHCP_HALF(1), .SCAN_DIV(SLOT),
    .SEG_ACTIVE_LOW(1'b1), .SEL_ACTIVE_LOW(1'b1)
  ) dut (
    .sys_clk(clk), .sys_rst(rst), .data(data), .point(point), .seg_en(seg_en),
    .sign(sign), .hex_mode(hex_mode), .lzb_en(lzb_en), .bright(bright),
    .stcp(stcp), .shcp(shcp), .ds(ds), .oe(oe), .frame_done(frame_done)
  );

  typedef struct packed {
    logic [23:0]       data;
    logic [5:0]        point;
    logic              seg_en;
    logic              sign;
    logic              hex_mode;
    logic              lzb_en;
    logic [3:0]        bright;
    logic [5:0][13:0]  w;
  } vec_t;

  vec_t vt[9];

  int nvec = 0;
  int nbad = 0;

  // Stream monitor: rebuilds each latched chain word from shcp/ds and timestamps stcp.
  int          cyc = -1;
  int          n   = 0;
  int          nfd = 0;
  logic [13:0] cap = '0;
  logic [13:0] lw[16];
  int          lc[16];
  int          fdc[4];
  logic        p_shcp = 1'b0, p_stcp = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      cyc = -1;
      n   = 0;
      nfd = 0;
    end else begin
      cyc++;
      if (shcp && !p_shcp) cap = {cap[W-2:0], ds};
      if (stcp && !p_stcp && n < 16) begin
        lw[n] = cap;
        lc[n] = cyc;
        n++;
      end
      if (frame_done && nfd < 4) begin
        fdc[nfd] = cyc;
        nfd++;
      end
    end
    p_shcp = shcp;
    p_stcp = stcp;
  end

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nbad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    data = v.data; point = v.point; seg_en = v.seg_en; sign = v.sign;
    hex_mode = v.hex_mode; lzb_en = v.lzb_en; bright = v.bright;
  endtask

  // Leaves the bench #1 into cycle 0 of a fresh frame.
  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Runs ncyc cycles from cycle 0 and counts oe samples off the PWM profile.
  task automatic run_cycles(input logic [3:0] b, input int ncyc, output int bad);
    bad = 0;
    for (int c = 0; c < ncyc; c++) begin
      if (c >= 1 && oe !== (((c % SLOT) < (int'(b) + 1) * 4) ? 1'b0 : 1'b1)) bad++;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int bad;
    int fr;
    logic [5:0][13:0] neww;

    vt[0] = '{24'h123456, 6'h00, 1'b1, 1'b0, 1'b1, 1'b0, 4'hF,
              {14'h1FF9, 14'h2FA4, 14'h37B0, 14'h3B99, 14'h3D92, 14'h3E82}};
    vt[1] = '{24'h000042, 6'h00, 1'b1, 1'b1, 1'b1, 1'b1, 4'h3,
              {14'h1FFF, 14'h2FFF, 14'h37FF, 14'h3BBF, 14'h3D99, 14'h3EA4}};
    vt[2] = '{24'h00AB0F, 6'h00, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0,
              {14'h1FC0, 14'h2FC0, 14'h37FF, 14'h3BFF, 14'h3DC0, 14'h3EFF}};
    vt[3] = '{24'hABCDEF, 6'h05, 1'b1, 1'b0, 1'b1, 1'b0, 4'h7,
              {14'h1F88, 14'h2F83, 14'h37C6, 14'h3B21, 14'h3D86, 14'h3E0E}};
    vt[4] = '{24'h888888, 6'h3F, 1'b0, 1'b0, 1'b1, 1'b0, 4'hF,
              {14'h1FFF, 14'h2FFF, 14'h37FF, 14'h3BFF, 14'h3DFF, 14'h3EFF}};
    vt[5] = '{24'h789012, 6'h00, 1'b1, 1'b1, 1'b1, 1'b0, 4'hA,
              {14'h1FBF, 14'h2F80, 14'h3790, 14'h3BC0, 14'h3DF9, 14'h3EA4}};
    vt[6] = '{24'h900000, 6'h00, 1'b1, 1'b1, 1'b1, 1'b1, 4'h1,
              {14'h1F90, 14'h2FC0, 14'h37C0, 14'h3BC0, 14'h3DC0, 14'h3EC0}};
    vt[7] = '{24'h000000, 6'h3F, 1'b1, 1'b0, 1'b1, 1'b1, 4'hF,
              {14'h1FFF, 14'h2FFF, 14'h37FF, 14'h3BFF, 14'h3DFF, 14'h3E40}};
    vt[8] = '{24'h0A0003, 6'h00, 1'b1, 1'b1, 1'b0, 1'b1, 4'hC,
              {14'h1FBF, 14'h2FFF, 14'h37C0, 14'h3BC0, 14'h3DC0, 14'h3EB0}};

    // Reset state in the first cycle after reset.
    apply(vt[0]);
    do_reset();
    chk("rst_stcp", int'(stcp), 0);
    chk("rst_shcp", int'(shcp), 0);
    chk("rst_ds", int'(ds), 0);
    chk("rst_oe", int'(oe), 1);
    chk("rst_frame_done", int'(frame_done), 0);

    // One full frame per vector.
    for (int i = 0; i < 9; i++) begin
      apply(vt[i]);
      do_reset();
      run_cycles(vt[i].bright, DIGITS * SLOT, bad);
      chk($sformatf("v%0d_oe_pwm_bad_cycles", i), bad, 0);
      chk($sformatf("v%0d_word_count", i), n, DIGITS);
      for (int k = 0; k < DIGITS; k++) begin
        chk($sformatf("v%0d_word_d%0d", i, k), int'(lw[k]), int'(vt[i].w[k]));
        chk($sformatf("v%0d_stcp_cycle_d%0d", i, k), lc[k], k * SLOT + T_LAT);
      end
      chk($sformatf("v%0d_frame_done_count", i), nfd, 1);
      chk($sformatf("v%0d_frame_done_cycle", i), fdc[0], (DIGITS - 1) * SLOT + T_LAT);
    end

    // Input change during the digit 2 slot lands only in the next frame.
    neww = {14'h1F82, 14'h2F92, 14'h3799, 14'h3BB0, 14'h3DA4, 14'h3EF9};
    apply(vt[0]);
    do_reset();
    run_cycles(vt[0].bright, 2 * SLOT + 2, bad);
    data = 24'h654321;
    run_cycles(vt[0].bright, 2 * DIGITS * SLOT - (2 * SLOT + 2), bad);
    chk("mid_word_count", n, 2 * DIGITS);
    for (int k = 0; k < DIGITS; k++) begin
      chk($sformatf("mid_old_frame_d%0d", k), int'(lw[k]), int'(vt[0].w[k]));
      chk($sformatf("mid_new_frame_d%0d", k), int'(lw[DIGITS + k]), int'(neww[k]));
    end
    chk("mid_frame_done_count", nfd, 2);
    fr = DIGITS * SLOT;
    chk("mid_frame_done_period", fdc[1] - fdc[0], fr);

    // Reset in the middle of shifting aborts the word and restarts at digit 0.
    apply(vt[0]);
    do_reset();
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("midrst_stcp", int'(stcp), 0);
    chk("midrst_shcp", int'(shcp), 0);
    chk("midrst_ds", int'(ds), 0);
    chk("midrst_oe", int'(oe), 1);
    run_cycles(vt[0].bright, SLOT, bad);
    chk("midrst_oe_pwm_bad_cycles", bad, 0);
    chk("midrst_word_count", n, 1);
    chk("midrst_first_word", int'(lw[0]), int'(vt[0].w[0]));
    chk("midrst_stcp_cycle", lc[0], T_LAT);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule
